// File: rtl/dma_copy_master.sv
// Bus initiator copying a byte block between address ranges over the synchronous
// cpu6502-style memory bus (read data valid the cycle after the address).
module dma_copy_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] AB,
  output logic [DATA_W-1:0] DO,
  output logic              WE,
  input  logic [DATA_W-1:0] DI
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_ab;
  logic [DATA_W-1:0] r_do;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_bus_req;

  logic [ADDR_W-1:0] w_src_inc;
  logic [ADDR_W-1:0] w_dst_inc;
  logic [LEN_W-1:0]  w_cnt_dec;
  logic              w_last;

  // Address increments wrap naturally at 2^ADDR_W.
  assign w_src_inc = r_src + ADDR_W'(1);
  assign w_dst_inc = r_dst + ADDR_W'(1);
  assign w_cnt_dec = r_cnt - LEN_W'(1);
  assign w_last    = (r_cnt == LEN_W'(1));

  assign busy    = r_busy;
  assign done    = r_done;
  assign bus_req = r_bus_req;
  assign AB      = r_ab;
  assign DO      = r_do;
  assign WE      = r_we;

  // Outputs are loaded on the transition into each state, so they always match
  // the current state; AB/DO/WE stay 0 outside RD/CAP/WR for OR-muxing.
  always_ff @(posedge cclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_ab      <= '0;
      r_do      <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bus_req <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_src     <= src_addr;
              r_dst     <= dst_addr;
              r_cnt     <= len;
              r_busy    <= 1'b1;
              r_bus_req <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            r_ab    <= r_src;
            r_we    <= 1'b0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_state <= S_CAP;
        end
        S_CAP: begin
          // r_do doubles as the data register holding the captured byte.
          r_ab    <= r_dst;
          r_do    <= DI;
          r_we    <= 1'b1;
          r_state <= S_WR;
        end
        S_WR: begin
          r_src <= w_src_inc;
          r_dst <= w_dst_inc;
          r_cnt <= w_cnt_dec;
          r_we  <= 1'b0;
          r_do  <= '0;
          if (w_last) begin
            r_ab      <= '0;
            r_busy    <= 1'b0;
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (bus_gnt) begin
            r_ab    <= w_src_inc;
            r_state <= S_RD;
          end else begin
            // Grant lost: release the bus at this byte boundary and re-request.
            r_ab    <= '0;
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_ab      <= '0;
          r_do      <= '0;
          r_we      <= 1'b0;
          r_busy    <= 1'b0;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
